isp_apb_page_buffer: RTL and testbench

APB3 completer that attaches to the MSS FIC_2 APB master port and buffers ISP image words written by Cortex-M3 firmware. Each accepted word goes into an internal FIFO and is folded into a running checksum. Words are then streamed out over a valid/ready interface to the fabric programming logic. The block lets firmware push an image page by register writes without stalling on the slower downstream consumer.

---
 rtl/isp_apb_page_buffer.sv | 156 +++++++++++++++
 tb/tb_isp_apb_page_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/isp_apb_page_buffer.sv
// rtl/isp_apb_page_buffer.sv - APB3 completer buffering ISP image words into a FIFO with checksum and stream output
// Firmware pushes words through DATA; a registered output stage drains them over ISP_DATA/ISP_VALID/ISP_READY.
module isp_apb_page_buffer #(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_STATES = 1
) (
   input  logic        PCLK,
   input  logic        PRESET_N,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [15:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [31:0] ISP_DATA,
   output logic        ISP_VALID,
   input  logic        ISP_READY,
   output logic        IRQ
);
   localparam int                DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [2:0]        WS      = 3'(WAIT_STATES);
   localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

   logic [2:0]          ws_q, ws_d;
   logic                en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
   logic                valid_q, valid_d, irq_q, irq_d;
   logic [31:0]         csum_q, csum_d, data_q, data_d;
   logic [DEPTH_LOG2:0] wr_q, wr_d, rd_q, rd_d, level;
   logic [31:0]         mem [DEPTH];
   logic [31:0]         rdata;

   logic access, commit, wr_fire, mapped;
   logic sel_ctrl, sel_status, sel_data, sel_level, sel_csum, unmapped;
   logic empty, full, push_req, push, ovf_hit, clear, load;
   logic [5:0] off;
   logic unused_paddr;

   assign unused_paddr = ^PADDR[1:0];

   assign access  = PSEL & PENABLE;
   assign PREADY  = (ws_q == WS);
   assign commit  = access & PREADY;
   assign wr_fire = commit & PWRITE;

   assign mapped     = (PADDR[15:8] == 8'h00);
   assign off        = PADDR[7:2];
   assign sel_ctrl   = mapped && (off == 6'd0);
   assign sel_status = mapped && (off == 6'd1);
   assign sel_data   = mapped && (off == 6'd2);
   assign sel_level  = mapped && (off == 6'd3);
   assign sel_csum   = mapped && (off == 6'd4);
   assign unmapped   = ~(sel_ctrl | sel_status | sel_data | sel_level | sel_csum);

   // Extra pointer MSB: difference reaches DEPTH only when full
   assign level = wr_q - rd_q;
   assign empty = (level == '0);
   assign full  = level[DEPTH_LOG2];

   assign push_req = wr_fire & sel_data;
   assign push     = push_req & ~full;
   assign ovf_hit  = push_req & full;
   assign clear    = wr_fire & sel_ctrl & PWDATA[1];
   assign load     = en_q & ~empty & (~valid_q | ISP_READY);

   always_comb begin
      ws_d     = ws_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      csum_d   = csum_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      data_d   = data_q;
      if (!PSEL || commit)
         ws_d = 3'd0;
      else if (access && (ws_q < WS))
         ws_d = ws_q + 3'd1;
      if (wr_fire && sel_ctrl) begin
         en_d     = PWDATA[0];
         irq_en_d = PWDATA[2];
      end
      if (push) begin
         wr_d   = wr_q + PTR_ONE;
         csum_d = csum_q + PWDATA;
      end
      if (ovf_hit)
         ovf_d = 1'b1;
      else if (wr_fire && sel_status && PWDATA[2])
         ovf_d = 1'b0;
      if (load) begin
         rd_d    = rd_q + PTR_ONE;
         data_d  = mem[rd_q[DEPTH_LOG2-1:0]];
         valid_d = 1'b1;
      end else if (valid_q && ISP_READY) begin
         valid_d = 1'b0;
      end
      // CLEAR aborts the stream even if a word is being held
      if (clear) begin
         wr_d    = '0;
         rd_d    = '0;
         csum_d  = 32'd0;
         ovf_d   = 1'b0;
         valid_d = 1'b0;
         data_d  = 32'd0;
      end
      irq_d = irq_en_q & (ovf_q | (en_q & empty & ~valid_q));
   end

   always_ff @(posedge PCLK or negedge PRESET_N) begin
      if (!PRESET_N) begin
         ws_q     <= 3'd0;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         csum_q   <= 32'd0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= 32'd0;
         irq_q    <= 1'b0;
      end else begin
         ws_q     <= ws_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         csum_q   <= csum_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         irq_q    <= irq_d;
      end
   end

   always_ff @(posedge PCLK) begin
      if (push)
         mem[wr_q[DEPTH_LOG2-1:0]] <= PWDATA;
   end

   always_comb begin
      rdata = 32'd0;
      if (sel_ctrl)   rdata = {29'd0, irq_en_q, 1'b0, en_q};
      if (sel_status) rdata = {28'd0, valid_q, ovf_q, full, empty};
      if (sel_level)  rdata = 32'(level);
      if (sel_csum)   rdata = csum_q;
   end

   assign PRDATA    = (access && PREADY && !PWRITE) ? rdata : 32'd0;
   assign PSLVERR   = commit & (unmapped | ovf_hit);
   assign ISP_DATA  = data_q;
   assign ISP_VALID = valid_q;
   assign IRQ       = irq_q;
endmodule

// File: tb/tb_isp_apb_page_buffer.sv
// tb/tb_isp_apb_page_buffer.sv - scoreboard bench for isp_apb_page_buffer
// APB responses and stream words are queued at issue time and checked by independent monitors.
module tb_isp_apb_page_buffer;
   localparam int WS = 1;
   localparam logic [15:0] A_CTRL = 16'h0000, A_STATUS = 16'h0004, A_DATA = 16'h0008,
                           A_LEVEL = 16'h000C, A_CSUM = 16'h0010;

   logic        PCLK = 1'b0;
   logic        PRESET_N = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [15:0] PADDR = 16'h0;
   logic [31:0] PWDATA = 32'h0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic [31:0] ISP_DATA;
   logic        ISP_VALID;
   logic        ISP_READY = 1'b1;
   logic        IRQ;

   int n_cmp = 0;
   int n_bad = 0;

   logic        q_wr[$];
   logic [15:0] q_addr[$];
   logic [31:0] q_rd[$];
   logic        q_err[$];
   logic [31:0] q_stream[$];

   isp_apb_page_buffer #(.DEPTH_LOG2(6), .WAIT_STATES(WS)) dut (
      .PCLK(PCLK), .PRESET_N(PRESET_N), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .ISP_DATA(ISP_DATA), .ISP_VALID(ISP_VALID), .ISP_READY(ISP_READY), .IRQ(IRQ)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // APB monitor: every completed transfer pops one expected response
   logic        m_wr, m_err;
   logic [15:0] m_addr;
   logic [31:0] m_rd;
   always @(negedge PCLK) begin
      if (PRESET_N && PSEL && PENABLE && PREADY) begin
         n_cmp++;
         if (q_wr.size() == 0) begin
            n_bad++;
            $display("FAIL apb_unexpected: transfer at 0x%04h with empty queue", PADDR);
         end else begin
            m_wr = q_wr.pop_front(); m_addr = q_addr.pop_front();
            m_rd = q_rd.pop_front(); m_err = q_err.pop_front();
            if (PADDR !== m_addr || PSLVERR !== m_err || (!m_wr && PRDATA !== m_rd)) begin
               n_bad++;
               $display("FAIL apb@%04h wr=%0b: got rdata 0x%08h err %0b expected rdata 0x%08h err %0b",
                        m_addr, m_wr, PRDATA, PSLVERR, m_rd, m_err);
            end
         end
      end
   end

   // Stream monitor: every accepted word pops one expected word
   logic [31:0] s_exp;
   always @(negedge PCLK) begin
      if (PRESET_N && ISP_VALID && ISP_READY) begin
         n_cmp++;
         if (q_stream.size() == 0) begin
            n_bad++;
            $display("FAIL stream_unexpected: got 0x%08h with empty queue", ISP_DATA);
         end else begin
            s_exp = q_stream.pop_front();
            if (ISP_DATA !== s_exp) begin
               n_bad++;
               $display("FAIL stream_word: got 0x%08h expected 0x%08h", ISP_DATA, s_exp);
            end
         end
      end
   end

   task automatic apb(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr);
      int  cyc;
      bit  done;
      q_wr.push_back(wr); q_addr.push_back(a); q_rd.push_back(erd); q_err.push_back(eerr);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      cyc = 2; done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge PCLK);
         if (PREADY) done = 1'b1;
         else begin
            @(posedge PCLK); #1;
            cyc++;
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL apb_timeout: PREADY never rose at 0x%04h", a);
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      check("apb_len", 32'(cyc), 32'(2 + WS));
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [31:0] d, input logic eerr);
      apb(1'b1, a, d, 32'h0, eerr);
   endtask

   task automatic rd_reg(input logic [15:0] a, input logic [31:0] erd, input logic eerr);
      apb(1'b0, a, 32'h0, erd, eerr);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      PRESET_N = 1'b1;
      @(negedge PCLK);
      check("rst_pready", 32'(PREADY), 32'h0);
      check("rst_prdata", PRDATA, 32'h0);
      check("rst_pslverr", 32'(PSLVERR), 32'h0);
      check("rst_valid", 32'(ISP_VALID), 32'h0);
      check("rst_data", ISP_DATA, 32'h0);
      check("rst_irq", 32'(IRQ), 32'h0);

      // Register basics
      rd_reg(A_STATUS, 32'h1, 1'b0);
      rd_reg(A_LEVEL, 32'h0, 1'b0);
      rd_reg(16'h0040, 32'h0, 1'b1);
      rd_reg(16'h0100, 32'h0, 1'b1);
      rd_reg(A_DATA, 32'h0, 1'b0);

      // Push two words with drain disabled, then drain with ISP_READY high
      wr_reg(A_DATA, 32'h11111111, 1'b0);
      wr_reg(A_DATA, 32'h22222222, 1'b0);
      rd_reg(A_LEVEL, 32'd2, 1'b0);
      rd_reg(A_CSUM, 32'h33333333, 1'b0);
      q_stream.push_back(32'h11111111);
      q_stream.push_back(32'h22222222);
      wr_reg(A_CTRL, 32'h1, 1'b0);
      @(negedge PCLK); check("drain_t1_valid", 32'(ISP_VALID), 32'h0);
      @(negedge PCLK); check("drain_t2_data", ISP_DATA, 32'h11111111);
      check("drain_t2_valid", 32'(ISP_VALID), 32'h1);
      @(negedge PCLK); check("drain_t3_data", ISP_DATA, 32'h22222222);
      @(negedge PCLK); check("drain_t4_valid", 32'(ISP_VALID), 32'h0);
      rd_reg(A_STATUS, 32'h1, 1'b0);

      // Write-to-stream latency
      q_stream.push_back(32'hA5A5A5A5);
      wr_reg(A_DATA, 32'hA5A5A5A5, 1'b0);
      @(negedge PCLK); check("lat_t1_valid", 32'(ISP_VALID), 32'h0);
      @(negedge PCLK); check("lat_t2_valid", 32'(ISP_VALID), 32'h1);
      check("lat_t2_data", ISP_DATA, 32'hA5A5A5A5);

      // Overflow with IRQ enabled, drain disabled
      wr_reg(A_CTRL, 32'h4, 1'b0);
      for (int i = 0; i < 64; i++) wr_reg(A_DATA, 32'h100 + 32'(i), 1'b0);
      rd_reg(A_STATUS, 32'h2, 1'b0);
      wr_reg(A_DATA, 32'hDEADBEEF, 1'b1);
      rd_reg(A_STATUS, 32'h6, 1'b0);
      rd_reg(A_LEVEL, 32'd64, 1'b0);
      rd_reg(A_CSUM, 32'hD8D920B8, 1'b0);
      @(negedge PCLK); check("ovf_irq", 32'(IRQ), 32'h1);
      wr_reg(A_STATUS, 32'h4, 1'b0);
      rd_reg(A_STATUS, 32'h2, 1'b0);
      @(negedge PCLK); check("ovf_irq_clr", 32'(IRQ), 32'h0);

      // Backpressure then CLEAR abort
      @(posedge PCLK); #1; ISP_READY = 1'b0;
      wr_reg(A_CTRL, 32'h1, 1'b0);
      repeat (2) @(negedge PCLK);
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         check("bp_valid", 32'(ISP_VALID), 32'h1);
         check("bp_data", ISP_DATA, 32'h100);
      end
      wr_reg(A_CTRL, 32'h3, 1'b0);
      @(negedge PCLK); check("clr_valid", 32'(ISP_VALID), 32'h0);
      check("clr_data", ISP_DATA, 32'h0);
      rd_reg(A_LEVEL, 32'h0, 1'b0);
      rd_reg(A_CSUM, 32'h0, 1'b0);
      rd_reg(A_CTRL, 32'h1, 1'b0);

      // Async reset in the middle of a held stream word and a read access
      wr_reg(A_DATA, 32'h10, 1'b0);
      wr_reg(A_DATA, 32'h20, 1'b0);
      wr_reg(A_DATA, 32'h30, 1'b0);
      rd_reg(A_CSUM, 32'h60, 1'b0);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_CSUM;
      @(posedge PCLK); #1; PENABLE = 1'b1;
      @(posedge PCLK); #1;
      check("pre_rst_prdata", PRDATA, 32'h60);
      check("pre_rst_valid", 32'(ISP_VALID), 32'h1);
      #1 PRESET_N = 1'b0;
      #1;
      check("async_valid", 32'(ISP_VALID), 32'h0);
      check("async_irq", 32'(IRQ), 32'h0);
      check("async_prdata", PRDATA, 32'h0);
      check("async_data", ISP_DATA, 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK); PRESET_N = 1'b1;
      ISP_READY = 1'b1;
      rd_reg(A_STATUS, 32'h1, 1'b0);
      rd_reg(A_CSUM, 32'h0, 1'b0);
      rd_reg(A_CTRL, 32'h0, 1'b0);

      repeat (3) @(negedge PCLK);
      check("apb_queue_left", 32'(q_wr.size()), 32'h0);
      check("stream_queue_left", 32'(q_stream.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
